// File: rtl/mem_io_responder.sv
// mem_io_responder: 128 KB RAM plus memory-mapped UART/stop/counter I/O on the byte-wide CPU bus.
// Defining IO_CYCLE_COUNTER_EN builds the cycle counter readable at 0x30004-0x30007.
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int FULL_MARGIN = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_done,
    output logic        tx_overflow
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(TX_FIFO_DEPTH);
    localparam logic [AW:0] FULL_TH = (AW+1)'(TX_FIFO_DEPTH - FULL_MARGIN);

    logic [7:0]    ram [2**RAM_ADDR_W];
    logic [7:0]    tx_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    rx_hold, rd_data, push_data, cnt_byte;
    logic          rx_full, is_ram, is_io, io_rd0, io_wr0, io_wr4;
    logic          push, pop, push_ok, load, unused_bits;

    assign unused_bits = ^mem_a[31:18];
    assign is_ram = !mem_a[17];
    assign is_io = mem_a[17:16] == 2'b11;
    assign io_rd0 = is_io && !mem_wr && mem_a[2:0] == 3'd0;
    assign io_wr0 = is_io && mem_wr && mem_a[2:0] == 3'd0;
    assign io_wr4 = is_io && mem_wr && mem_a[2:0] == 3'd4;
    assign push = (io_wr0 && mem_dout != 8'h00) || io_wr4;
    assign push_data = io_wr4 ? 8'h00 : mem_dout;
    assign pop = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (count != DEPTH || pop);
    assign load = rx_valid && !rx_full;
    assign tx_valid = count != '0;
    assign tx_data = tx_valid ? tx_mem[rd_ptr] : 8'h00;
    assign io_buffer_full = count >= FULL_TH;
    assign rx_ready = !rx_full;

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cyc, snap;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cyc <= '0;
            snap <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            if (is_io && !mem_wr && mem_a[2:0] == 3'd4) snap <= cyc;
        end
    end
    assign cnt_byte = mem_a[1:0] == 2'd0 ? cyc[7:0] :
                      mem_a[1:0] == 2'd1 ? snap[15:8] :
                      mem_a[1:0] == 2'd2 ? snap[23:16] : snap[31:24];
`else
    assign cnt_byte = 8'h00;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (!mem_wr && is_ram) rd_data = ram[mem_a[RAM_ADDR_W-1:0]];
        else if (!mem_wr && is_io) rd_data = mem_a[2] ? cnt_byte : (io_rd0 && rx_full ? rx_hold : 8'h00);
    end

    always_ff @(posedge clk_in) begin
        if (mem_wr && is_ram) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
        if (push_ok) tx_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rx_full <= 1'b0;
            rx_hold <= 8'h00;
            prog_done <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            mem_din <= rd_data;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
            if (push && !push_ok) tx_overflow <= 1'b1;
            if (io_wr4) prog_done <= 1'b1;
            // A load can only happen while empty, so a same-cycle read still sees nothing.
            rx_full <= load ? 1'b1 : (io_rd0 ? 1'b0 : rx_full);
            if (load) rx_hold <= rx_data;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;
    logic        clk_in = 1'b0, rst_in = 1'b1;
    logic [31:0] mem_a = 32'h20000;
    logic [7:0]  mem_dout = 8'h00, rx_data = 8'h00;
    logic        mem_wr = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
    logic [7:0]  mem_din, tx_data;
    logic        io_buffer_full, tx_valid, rx_ready, prog_done, tx_overflow;
    int          passed = 0, total = 0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .prog_done(prog_done), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic do_reset();
        mem_a = 32'h20000; mem_wr = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // One bus request spanning exactly one rising edge; the bus returns to an unmapped idle read.
    task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
        mem_a = a; mem_wr = w; mem_dout = d;
        @(negedge clk_in);
        mem_a = 32'h20000; mem_wr = 1'b0; mem_dout = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mem_din !== 8'h00) $display("FAIL rst_mem_din got=%h exp=00", mem_din); else passed++;
        total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got=%h exp=00", tx_data); else passed++;
        total++; if (io_buffer_full !== 1'b0) $display("FAIL rst_full got=%b exp=0", io_buffer_full); else passed++;
        total++; if (rx_ready !== 1'b1) $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); else passed++;
        total++; if (prog_done !== 1'b0) $display("FAIL rst_prog_done got=%b exp=0", prog_done); else passed++;
        total++; if (tx_overflow !== 1'b0) $display("FAIL rst_overflow got=%b exp=0", tx_overflow); else passed++;
    endtask

    task automatic test_counter();
        logic [31:0] exp_cnt;
`ifdef IO_CYCLE_COUNTER_EN
        exp_cnt = 32'h00000105;
`else
        exp_cnt = 32'h00000000;
`endif
        do_reset();
        repeat (32'h105) @(negedge clk_in);
        for (int k = 0; k < 4; k++) begin
            bus(32'h30004 + 32'(k), 1'b0, 8'h00);
            total++;
            if (mem_din !== exp_cnt[8*k +: 8]) $display("FAIL counter_byte%0d got=%h exp=%h", k, mem_din, exp_cnt[8*k +: 8]);
            else passed++;
        end
    endtask

    task automatic test_ram();
        do_reset();
        bus(32'h1FFFF, 1'b1, 8'hA5);
        bus(32'h1FFFF, 1'b0, 8'h00);
        total++; if (mem_din !== 8'hA5) $display("FAIL ram_top got=%h exp=a5", mem_din); else passed++;
        bus(32'h00000, 1'b1, 8'h3C);
        bus(32'h00000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h3C) $display("FAIL ram_bottom got=%h exp=3c", mem_din); else passed++;
        bus(32'h20000, 1'b1, 8'hFF);
        bus(32'h20000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h00) $display("FAIL unmapped_rd got=%h exp=00", mem_din); else passed++;
        bus(32'h1FFFF, 1'b0, 8'h00);
        total++; if (mem_din !== 8'hA5) $display("FAIL ram_keep got=%h exp=a5", mem_din); else passed++;
    endtask

    task automatic test_output();
        do_reset();
        bus(32'h30000, 1'b1, 8'h48);
        bus(32'h30000, 1'b1, 8'h00);
        bus(32'h30000, 1'b1, 8'h69);
        total++; if (tx_valid !== 1'b1) $display("FAIL out_valid got=%b exp=1", tx_valid); else passed++;
        total++; if (tx_data !== 8'h48) $display("FAIL out_head got=%h exp=48", tx_data); else passed++;
        tx_ready = 1'b1;
        @(negedge clk_in);
        total++; if (tx_data !== 8'h69) $display("FAIL out_second got=%h exp=69", tx_data); else passed++;
        @(negedge clk_in);
        total++; if (tx_valid !== 1'b0) $display("FAIL out_empty got=%b exp=0", tx_valid); else passed++;
        tx_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        do_reset();
        for (int i = 1; i <= 11; i++) bus(32'h30000, 1'b1, 8'(i));
        total++; if (io_buffer_full !== 1'b0) $display("FAIL bp_full11 got=%b exp=0", io_buffer_full); else passed++;
        bus(32'h30000, 1'b1, 8'd12);
        total++; if (io_buffer_full !== 1'b1) $display("FAIL bp_full12 got=%b exp=1", io_buffer_full); else passed++;
        for (int i = 13; i <= 16; i++) bus(32'h30000, 1'b1, 8'(i));
        total++; if (tx_overflow !== 1'b0) $display("FAIL bp_ovf16 got=%b exp=0", tx_overflow); else passed++;
        tx_ready = 1'b1;
        bus(32'h30000, 1'b1, 8'h77);
        tx_ready = 1'b0;
        total++; if (tx_overflow !== 1'b0) $display("FAIL bp_pushpop_ovf got=%b exp=0", tx_overflow); else passed++;
        total++; if (tx_data !== 8'h02) $display("FAIL bp_pushpop_head got=%h exp=02", tx_data); else passed++;
        bus(32'h30000, 1'b1, 8'h88);
        total++; if (tx_overflow !== 1'b1) $display("FAIL bp_ovf17 got=%b exp=1", tx_overflow); else passed++;
        tx_ready = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            e = (i == 17) ? 8'h77 : 8'(i);
            total++; if (tx_data !== e) $display("FAIL bp_drain%0d got=%h exp=%h", i, tx_data, e); else passed++;
            @(negedge clk_in);
        end
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", tx_valid); else passed++;
        total++; if (io_buffer_full !== 1'b0) $display("FAIL bp_full_clear got=%b exp=0", io_buffer_full); else passed++;
    endtask

    task automatic test_input();
        do_reset();
        rx_data = 8'h37; rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
        total++; if (rx_ready !== 1'b0) $display("FAIL in_held got=%b exp=0", rx_ready); else passed++;
        bus(32'h30000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h37) $display("FAIL in_read got=%h exp=37", mem_din); else passed++;
        total++; if (rx_ready !== 1'b1) $display("FAIL in_freed got=%b exp=1", rx_ready); else passed++;
        bus(32'h30000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h00) $display("FAIL in_reread got=%h exp=00", mem_din); else passed++;
        rx_data = 8'h5A; rx_valid = 1'b1;
        bus(32'h30000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        total++; if (mem_din !== 8'h00) $display("FAIL in_race_rd got=%h exp=00", mem_din); else passed++;
        total++; if (rx_ready !== 1'b0) $display("FAIL in_race_held got=%b exp=0", rx_ready); else passed++;
        bus(32'h30000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h5A) $display("FAIL in_race_after got=%h exp=5a", mem_din); else passed++;
    endtask

    task automatic test_stop();
        do_reset();
        bus(32'h30004, 1'b1, 8'hEE);
        total++; if (prog_done !== 1'b1) $display("FAIL stop_done got=%b exp=1", prog_done); else passed++;
        total++; if (tx_valid !== 1'b1) $display("FAIL stop_term_valid got=%b exp=1", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL stop_term_data got=%h exp=00", tx_data); else passed++;
        bus(32'h30000, 1'b1, 8'h41);
        rx_data = 8'h11; rx_valid = 1'b1;
        bus(32'h1FFFF, 1'b0, 8'h00);
        rx_valid = 1'b0;
        total++; if (mem_din !== 8'hA5) $display("FAIL stop_pre_rd got=%h exp=a5", mem_din); else passed++;
        tx_ready = 1'b1;
        #1 rst_in = 1'b1;
        #1;
        total++; if (mem_din !== 8'h00) $display("FAIL arst_mem_din got=%h exp=00", mem_din); else passed++;
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL arst_tx got=%b/%h exp=0/00", tx_valid, tx_data); else passed++;
        total++; if (prog_done !== 1'b0) $display("FAIL arst_done got=%b exp=0", prog_done); else passed++;
        total++; if (rx_ready !== 1'b1) $display("FAIL arst_rx_ready got=%b exp=1", rx_ready); else passed++;
        total++; if (io_buffer_full !== 1'b0 || tx_overflow !== 1'b0) $display("FAIL arst_flags got=%b/%b exp=0/0", io_buffer_full, tx_overflow); else passed++;
        tx_ready = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_ram();
        test_output();
        test_backpressure();
        test_input();
        test_stop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus. Serves a 128 KB RAM and the memory-mapped I/O window above 0x30000: read data returns one cycle after the request, writes complete in one cycle. Queues UART output bytes, drives `io_buffer_full` back to the CPU, holds one received input byte, supplies the cycle counter, and flags program stop. Sits between the CPU top and the UART/host interface.

## Interface
- `RAM_ADDR_W`, 17, RAM address width; RAM is 2^17 bytes.
- `TX_FIFO_DEPTH`, 16, output FIFO depth; must be a power of 2, ≥ 8.
- `FULL_MARGIN`, 4, free-slot headroom below which `io_buffer_full` asserts.

- `clk_in` in 1: the block's one clock.
- `rst_in` in 1: reset, asynchronous and active-high.
- `mem_a` in 32: byte address from the CPU; only [17:0] decoded.
- `mem_dout` in 8: write data from the CPU.
- `mem_wr` in 1: 1 = write, 0 = read; a request is presented every cycle.
- `mem_din` out 8: registered read data to the CPU.
- `io_buffer_full` out 1: output FIFO near full.
- `tx_data` out 8: head byte of the output FIFO.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: UART accepts `tx_data` this cycle.
- `rx_data` in 8, `rx_valid` in 1: input byte offer.
- `rx_ready` out 1: input holding register empty.
- `prog_done` out 1: sticky; program stop was written.
- `tx_overflow` out 1: sticky; a byte was dropped because the FIFO was full.

## Operation
- Decode on `mem_a[17:16]`:
  - `2'b00` and `2'b01`: RAM.
  - `2'b10`: unmapped. Reads return 0x00; writes are ignored.
  - `2'b11`: I/O, selected by `mem_a[2:0]`.
- RAM contents are not reset.
  - Write: `mem_wr`=1 stores `mem_dout` at the clock edge.
  - Read: the data appears on `mem_din` the next cycle.
- 0x30000 write: pushes `mem_dout` into the output FIFO. Value 0x00 is ignored (no push).
- 0x30000 read: returns the held input byte and empties the holding register. If nothing is held, returns 0x00 and changes nothing.
- 0x30004 write: sets `prog_done`, then pushes 0x00 into the FIFO as the terminator. The push is subject to the full rule below.
- 0x30004–0x30007 read: little-endian bytes of the 32-bit cycle counter.
  - A read of 0x30004 returns counter bits [7:0] and snapshots the whole counter in the same cycle.
  - 0x30005/6/7 return snapshot bytes 1/2/3.
- Other I/O offsets: reads return 0x00; writes are ignored.
- Output FIFO:
  - Pop when `tx_valid && tx_ready`.
  - A push while the FIFO is full drops the byte and sets `tx_overflow`.
  - A simultaneous push and pop in the same cycle both take effect, including when the FIFO is full (the pop frees the slot).
  - `io_buffer_full` = `count >= TX_FIFO_DEPTH - FULL_MARGIN`, combinational from the registered count.
- Input holding register:
  - Loads `rx_data` when `rx_valid && rx_ready`.
  - If a CPU read of 0x30000 and a load happen in the same cycle, the read returns the old (empty) state, i.e. 0x00, and the new byte is held.
- Cycle counter:
  - Increments every cycle after reset release.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: `mem_din`=0x00, FIFO empty (`tx_valid`=0, `tx_data`=0x00), `io_buffer_full`=0, `rx_ready`=1, `prog_done`=0, `tx_overflow`=0, counter=0, snapshot=0.
- Read latency is exactly 1 cycle for every region; no wait states exist.
- Back-to-back requests on consecutive cycles are fully supported, including:
  - a write followed by a read of the same address, which returns the new data;
  - a read in the same cycle as a write to the same address, which returns the old data.
- A byte pushed at edge t drives `tx_valid` from t onward.
- `io_buffer_full` reflects the count after edge t, visible in cycle t+1.
- Asserting reset mid-operation clears all state except RAM immediately (asynchronously).

## Configuration
- `IO_CYCLE_COUNTER_EN`:
  - Defined: the counter, the snapshot and the 0x30004–0x30007 read path are built as described above.
  - Undefined: the counter and snapshot are removed, and 0x30004–0x30007 reads return 0x00.
  - 0x30004 write behaviour is identical in both builds.

## Test plan
- RAM round trip: write 0xA5 to 0x1FFFF, then read 0x1FFFF next cycle → `mem_din`=0xA5 one cycle after the read; a read of 0x20000 → 0x00.
- Output path with `tx_ready`=0: write 0x48, 0x00, 0x69 to 0x30000 → FIFO holds 2 bytes, `tx_data`=0x48; raise `tx_ready` → 0x48 then 0x69 leave, then `tx_valid`=0.
- Back-pressure at defaults with `tx_ready`=0: after 12 pushes, `io_buffer_full`=1; 16 pushes fill the FIFO; the 17th push sets `tx_overflow` and is dropped.
- Counter (macro defined): hold the bus idle for 0x105 cycles after reset, then read 0x30004..0x30007 on consecutive cycles → 0x05, 0x01, 0x00, 0x00. Without the macro → all 0x00.
- Input: offer `rx_data`=0x37 → `rx_ready` falls; read 0x30000 → 0x37 and `rx_ready`=1; a second read → 0x00.
- Stop: write 0x30004 → `prog_done`=1 and 0x00 is queued on `tx_data`; assert `rst_in` mid-burst → all outputs at reset values within the same cycle.
